tetris_move_encoder: RTL and testbench

Turns the five raw player buttons into `tetris_pkg::move_t` commands for the game FSM. It synchronizes and debounces each button, detects presses, and auto-repeats held RIGHT/LEFT/DOWN. Commands are delivered one at a time over a valid/ready handshake. It is the producing end of the `move_t` interface, sitting between the board button pins and the falling-block states of the game controller.

---
 rtl/tetris_move_encoder.sv | 165 ++++++++++++++++
 tb/tb_tetris_move_encoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tetris_move_encoder.sv
// Five raw buttons -> move_t commands: 2-flop sync, debounce, press detect, auto-repeat (RIGHT/LEFT/DOWN), one pending flag per move.
// Latency DEBOUNCE_CYCLES+4 from first raw sample to move_valid; move holds until move_ready, events for an already-pending move coalesce.
package tetris_pkg;
  typedef enum logic [2:0] {
    MOVE_RIGHT = 3'd0,
    MOVE_LEFT  = 3'd1,
    MOVE_ROR   = 3'd2,
    MOVE_ROL   = 3'd3,
    MOVE_DOWN  = 3'd4
  } move_t;
endpackage

module tetris_move_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_right,
  input  logic               btn_left,
  input  logic               btn_ror,
  input  logic               btn_rol,
  input  logic               btn_down,
  input  logic               move_ready,
  output logic               move_valid,
  output tetris_pkg::move_t  move
);
  import tetris_pkg::*;

  localparam int NB   = 5;
  localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DMAX = DCW'(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [RCW-1:0] RDLY = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RPER = RCW'(REPEAT_PERIOD - 1);
  // Bit order follows move_t: {DOWN, ROL, ROR, LEFT, RIGHT}; rotations never repeat.
  localparam logic [NB-1:0] RPT_EN = 5'b10011;

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  logic [NB-1:0]  btn, sync1, sync2, stable, stable_q;
  logic [NB-1:0]  press, rpt_evt, events, rpt_act, flags, sel_oh;
  logic [DCW-1:0] dcnt [NB];
  logic [RCW-1:0] rcnt [NB];
  state_t         state;
  move_t          sel;
  logic           take;

  assign btn = {btn_down, btn_rol, btn_ror, btn_left, btn_right};

  // Debounce: after DEBOUNCE_CYCLES consecutive mismatching samples the level flips on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < NB; i++) dcnt[i] <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < NB; i++) begin
        if (dcnt[i] == DMAX) begin
          stable[i] <= ~stable[i];
          dcnt[i]   <= '0;
        end else if (sync2[i] != stable[i]) begin
          dcnt[i] <= dcnt[i] + DCW'(1);
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  assign press  = stable & ~stable_q;
  assign events = press | rpt_evt;

  always_comb begin
    rpt_evt = '0;
    for (int i = 0; i < NB; i++)
      rpt_evt[i] = RPT_EN[i] && rpt_act[i] && stable[i] && (rcnt[i] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_act <= '0;
      for (int i = 0; i < NB; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (!RPT_EN[i] || !stable[i]) begin
          rpt_act[i] <= 1'b0;
          rcnt[i]    <= '0;
        end else if (press[i]) begin
          rpt_act[i] <= 1'b1;
          rcnt[i]    <= RDLY;
        end else if (rpt_evt[i]) begin
          rcnt[i] <= RPER;
        end else if (rpt_act[i]) begin
          rcnt[i] <= rcnt[i] - RCW'(1);
        end
      end
    end
  end

  always_comb begin
    sel    = MOVE_RIGHT;
    sel_oh = '0;
    if (flags[4]) begin
      sel    = MOVE_DOWN;
      sel_oh = 5'b10000;
    end else if (flags[2]) begin
      sel    = MOVE_ROR;
      sel_oh = 5'b00100;
    end else if (flags[3]) begin
      sel    = MOVE_ROL;
      sel_oh = 5'b01000;
    end else if (flags[1]) begin
      sel    = MOVE_LEFT;
      sel_oh = 5'b00010;
    end else if (flags[0]) begin
      sel    = MOVE_RIGHT;
      sel_oh = 5'b00001;
    end
    take = (|flags) && ((state == S_IDLE) || move_ready);
  end

  // Selection reads registered flags, so an event landing on a load cycle waits one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      move_valid <= 1'b0;
      move       <= MOVE_RIGHT;
      flags      <= '0;
    end else begin
      flags <= (flags & ~(sel_oh & {NB{take}})) | events;
      case (state)
        S_IDLE: begin
          if (take) begin
            move       <= sel;
            move_valid <= 1'b1;
            state      <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (move_ready) begin
            if (take) begin
              move <= sel;
            end else begin
              move_valid <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        default: begin
          move_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_move_encoder.sv
// Directed bench for tetris_move_encoder with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=4.
module tb_tetris_move_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_right = 1'b0, btn_left = 1'b0, btn_ror = 1'b0, btn_rol = 1'b0, btn_down = 1'b0;
  logic       move_ready = 1'b1;
  logic       move_valid;
  logic [2:0] move;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vld_cnt  = 0;
  int rise_cyc = -1;
  logic vld_q  = 1'b0;
  logic [2:0] hs_mv[$];
  int         hs_cyc[$];

  tetris_move_encoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_right(btn_right),
    .btn_left(btn_left),
    .btn_ror(btn_ror),
    .btn_rol(btn_rol),
    .btn_down(btn_down),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move(move)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake log, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (move_valid) vld_cnt++;
      if (move_valid && !vld_q) rise_cyc = cyc;
      if (move_valid && move_ready) begin
        hs_mv.push_back(move);
        hs_cyc.push_back(cyc);
      end
    end
    vld_q = move_valid;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    hs_mv.delete();
    hs_cyc.delete();
    vld_cnt  = 0;
    rise_cyc = -1;
  endtask

  function automatic int qmv(input int i);
    return (i < hs_mv.size()) ? int'(hs_mv[i]) : -1;
  endfunction

  function automatic int qcyc(input int i);
    return (i < hs_cyc.size()) ? hs_cyc[i] : -1;
  endfunction

  initial begin
    int t0;
    int offs[7];
    offs = '{0, 10, 14, 18, 22, 26, 30};

    // Reset state
    tick(3);
    check("reset_valid", int'(move_valid), 0);
    check("reset_move", int'(move), 0);
    rst = 1'b0;
    tick(2);

    // Clean ROR press: one command, D+4 latency, no repeat, nothing on release
    clear_log();
    t0 = cyc;
    btn_ror = 1'b1;
    tick(20);
    check("ror_rise_cycle", rise_cyc, t0 + 9);
    check("ror_count", hs_mv.size(), 1);
    check("ror_move", qmv(0), 2);
    check("ror_valid_cycles", vld_cnt, 1);
    btn_ror = 1'b0;
    tick(12);
    check("ror_release_count", hs_mv.size(), 1);

    // Bounce rejection
    clear_log();
    for (int i = 0; i < 30; i++) begin
      btn_left = (((i / 2) % 2) == 1);
      tick(1);
    end
    btn_left = 1'b0;
    tick(12);
    check("bounce_count", hs_mv.size(), 0);
    check("bounce_valid_cycles", vld_cnt, 0);
    for (int i = 0; i < 30; i++) begin
      btn_left = (((i / 2) % 2) == 1);
      tick(1);
    end
    btn_left = 1'b1;
    tick(10);
    btn_left = 1'b0;
    tick(20);
    check("bounce_high_count", hs_mv.size(), 1);
    check("bounce_high_move", qmv(0), 1);

    // Auto-repeat DOWN
    clear_log();
    t0 = cyc;
    btn_down = 1'b1;
    tick(33);
    btn_down = 1'b0;
    tick(20);
    check("rpt_count", hs_mv.size(), 7);
    check("rpt_first_cycle", qcyc(0), t0 + 9);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("rpt_move_%0d", i), qmv(i), 4);
      check($sformatf("rpt_offset_%0d", i), qcyc(i) - qcyc(0), offs[i]);
    end

    // Backpressure and priority
    clear_log();
    move_ready = 1'b0;
    btn_right = 1'b1;
    btn_rol   = 1'b1;
    btn_down  = 1'b1;
    tick(8);
    btn_right = 1'b0;
    btn_rol   = 1'b0;
    btn_down  = 1'b0;
    tick(12);
    check("bp_valid_a", int'(move_valid), 1);
    check("bp_move_a", int'(move), 4);
    tick(5);
    check("bp_valid_b", int'(move_valid), 1);
    check("bp_move_b", int'(move), 4);
    t0 = cyc;
    move_ready = 1'b1;
    tick(6);
    check("bp_count", hs_mv.size(), 3);
    check("bp_seq0", qmv(0), 4);
    check("bp_seq1", qmv(1), 3);
    check("bp_seq2", qmv(2), 0);
    check("bp_cyc0", qcyc(0), t0);
    check("bp_cyc1", qcyc(1), t0 + 1);
    check("bp_cyc2", qcyc(2), t0 + 2);
    check("bp_idle_after", int'(move_valid), 0);

    // Coalescing of held LEFT repeats
    clear_log();
    move_ready = 1'b0;
    btn_left = 1'b1;
    tick(48);
    btn_left = 1'b0;
    tick(12);
    check("coal_held_valid", int'(move_valid), 1);
    check("coal_held_move", int'(move), 1);
    move_ready = 1'b1;
    tick(6);
    check("coal_count", hs_mv.size(), 2);
    check("coal_move0", qmv(0), 1);
    check("coal_move1", qmv(1), 1);
    check("coal_idle_after", int'(move_valid), 0);

    // Reset mid-OFFER with buttons held through release
    clear_log();
    move_ready = 1'b0;
    btn_rol   = 1'b1;
    btn_right = 1'b1;
    tick(12);
    check("mid_valid_pre", int'(move_valid), 1);
    check("mid_move_pre", int'(move), 3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_valid_async", int'(move_valid), 0);
    check("mid_move_async", int'(move), 0);
    tick(1);
    clear_log();
    rst = 1'b0;
    move_ready = 1'b1;
    t0 = cyc;
    tick(14);
    check("mid_first_move", qmv(0), 3);
    check("mid_first_cycle", qcyc(0), t0 + 9);
    check("mid_second_move", qmv(1), 0);
    check("mid_second_cycle", qcyc(1), t0 + 10);
    btn_rol   = 1'b0;
    btn_right = 1'b0;
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
